gpr_wb_ctrl: RTL and testbench
==============================

GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

Interface
REQ-001 SHALL have parameters: REG_NUM, default 32, register count; REG_ADDR_W, default 5, register address width; WORD_DATA_W, default 32, data width.
REQ-002 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports iss_valid, input, 1; iss_addr, input, REG_ADDR_W; iss_rdy, output, 1: decode announces a future write to iss_addr.
REQ-005 SHALL have ports ex_req, input, 1; ex_addr, input, REG_ADDR_W; ex_data, input, WORD_DATA_W; ex_rdy, output, 1: ALU writeback requester.
REQ-006 SHALL have ports mem_req, input, 1; mem_addr, input, REG_ADDR_W; mem_data, input, WORD_DATA_W: load writeback requester, no backpressure.
REQ-007 SHALL have ports rd_addr_0, rd_addr_1, input, REG_ADDR_W; rd_stall_0, rd_stall_1, output, 1: read-hazard query.
REQ-008 SHALL have ports gpr_we_, output, 1, active-low; gpr_wr_addr, output, REG_ADDR_W; gpr_wr_data, output, WORD_DATA_W: the single GPR write port.

Function
REQ-009 SHALL select one write per cycle, priority: mem_req, then FIFO head, then ex_req (bypass when FIFO empty).
REQ-010 SHALL register the selected write into gpr_we_/gpr_wr_addr/gpr_wr_data, visible the cycle after selection; no selection -> gpr_we_=1, addr/data hold.
REQ-011 SHALL accept ex_req only when ex_rdy=1; an accepted, unselected ex request SHALL be pushed into a 2-entry in-order FIFO.
REQ-012 SHALL drive ex_rdy = (FIFO count < 2), from registered count only; a same-cycle pop does not raise ex_rdy.
REQ-013 On mem_req, FIFO entries whose address equals mem_addr SHALL be squashed (removed, survivors compacted in order) the same cycle; a same-cycle incoming ex request to that address SHALL NOT be squashed (it is younger).
REQ-014 SHALL keep a 2-bit pending counter per register; iss_valid && iss_rdy increments counter[iss_addr].
REQ-015 Each selected write and each squashed entry SHALL decrement its register's counter by one; net update = increments - decrements in one cycle, never below 0.
REQ-016 SHALL drive iss_rdy = (counter[iss_addr] != 3).
REQ-017 SHALL drive rd_stall_n = (counter[rd_addr_n] != 0), combinational.
REQ-018 Counter reaching 0 coincides with the write entering the output register; GPR write-through covers the following read.
REQ-019 ex_req or mem_req to a register with counter 0 is a protocol error; counters SHALL saturate at 0, the write still performed.

Reset
REQ-020 While reset=1: all counters 0, FIFO empty, gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, ex_rdy=1, iss_rdy=1, rd_stall_n=0.
REQ-021 Reset mid-operation SHALL discard FIFO contents and pending counts with no GPR write issued.

Structure
REQ-022 REG_NUM, address/data widths, and ENABLE_/DISABLE_ active-low encodings SHALL come from the shared CPU package.
REQ-023 The 2-entry FIFO with squash/compaction SHALL be sub-module gpr_wb_fifo; scoreboard and arbitration stay in gpr_wb_ctrl.

Verification
REQ-024 iss r5, then ex_req r5=0x11 alone -> next cycle gpr_we_=0, addr 5, data 0x11; rd_stall for r5 drops the cycle after ex acceptance.
REQ-025 Same cycle mem_req r3=0xA, ex_req r4=0xB (FIFO empty) -> cycle+1 writes r3, cycle+2 writes r4; ex_rdy stays 1.
REQ-026 mem_req held 3 cycles with ex_req each cycle -> two ex pushes, ex_rdy=0 on third; drains in order after mem_req drops.
REQ-027 FIFO holds r7=0x1, r8=0x2; mem_req r7=0x3 -> r7 entry squashed, GPR sees r7=0x3 then r8=0x2; counter[r7] decremented twice.
REQ-028 Three iss to r9 -> iss_rdy=0 for r9; reset asserted mid-drain -> gpr_we_=1, all stalls 0, ex_rdy=1 immediately.

Source files
------------

// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared CPU definitions used by the GPR writeback controller:
// register file geometry and active-low enable encodings.
package gpr_wb_ctrl_pkg;

    localparam int unsigned CPU_REG_NUM     = 32;
    localparam int unsigned CPU_REG_ADDR_W  = 5;
    localparam int unsigned CPU_WORD_DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Two-entry in-order writeback FIFO with address squash and compaction;
// reports how many entries were squashed so the scoreboard can retire them.
module gpr_wb_fifo #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash,
    input  logic [ADDR_W-1:0] squash_addr,
    output logic [1:0]        count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        squash_cnt
);

    logic [ADDR_W-1:0] addr_q [2];
    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic [DATA_W-1:0] data_d [2];
    logic [1:0]        count_q, count_d;
    logic              hit0, hit1, keep0, keep1;
    logic [1:0]        keep_cnt;

    assign count     = count_q;
    assign head_addr = addr_q[0];
    assign head_data = data_q[0];

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        hit0     = squash && (count_q != 2'd0) && (addr_q[0] == squash_addr);
        hit1     = squash && (count_q == 2'd2) && (addr_q[1] == squash_addr);
        keep0    = (count_q != 2'd0) && !pop && !hit0;
        keep1    = (count_q == 2'd2) && !hit1;
        keep_cnt = {1'b0, keep0} + {1'b0, keep1};
        squash_cnt = {1'b0, hit0} + {1'b0, hit1};
        // Survivors slide toward the head; the push lands behind them.
        if (!keep0 && keep1) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
        end
        if (push) begin
            if (keep_cnt == 2'd0) begin
                addr_d[0] = push_addr;
                data_d[0] = push_data;
            end else begin
                addr_d[1] = push_addr;
                data_d[1] = push_data;
            end
        end
        count_d = keep_cnt + {1'b0, push};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: arbitrates load/ALU writebacks onto the single
// GPR write port and tracks pending writes per register for hazard stalls.
module gpr_wb_ctrl
    import gpr_wb_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM     = CPU_REG_NUM,
    parameter int unsigned REG_ADDR_W  = CPU_REG_ADDR_W,
    parameter int unsigned WORD_DATA_W = CPU_WORD_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_valid,
    input  logic [REG_ADDR_W-1:0]  iss_addr,
    output logic                   iss_rdy,
    input  logic                   ex_req,
    input  logic [REG_ADDR_W-1:0]  ex_addr,
    input  logic [WORD_DATA_W-1:0] ex_data,
    output logic                   ex_rdy,
    input  logic                   mem_req,
    input  logic [REG_ADDR_W-1:0]  mem_addr,
    input  logic [WORD_DATA_W-1:0] mem_data,
    input  logic [REG_ADDR_W-1:0]  rd_addr_0,
    input  logic [REG_ADDR_W-1:0]  rd_addr_1,
    output logic                   rd_stall_0,
    output logic                   rd_stall_1,
    output logic                   gpr_we_,
    output logic [REG_ADDR_W-1:0]  gpr_wr_addr,
    output logic [WORD_DATA_W-1:0] gpr_wr_data
);

    logic [1:0]             cnt_q [REG_NUM];
    logic [1:0]             cnt_d [REG_NUM];
    logic [1:0]             fifo_count, squash_cnt;
    logic [REG_ADDR_W-1:0]  head_addr;
    logic [WORD_DATA_W-1:0] head_data;
    logic                   ex_acc, push, pop, iss_fire;
    logic                   sel_valid;
    logic [REG_ADDR_W-1:0]  sel_addr;
    logic [WORD_DATA_W-1:0] sel_data;

    gpr_wb_fifo #(
        .ADDR_W (REG_ADDR_W),
        .DATA_W (WORD_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (ex_addr),
        .push_data   (ex_data),
        .pop         (pop),
        .squash      (mem_req),
        .squash_addr (mem_addr),
        .count       (fifo_count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .squash_cnt  (squash_cnt)
    );

    assign ex_rdy     = (fifo_count != 2'd2);
    assign iss_rdy    = (cnt_q[iss_addr] != 2'd3);
    assign iss_fire   = iss_valid && iss_rdy;
    assign rd_stall_0 = (cnt_q[rd_addr_0] != 2'd0);
    assign rd_stall_1 = (cnt_q[rd_addr_1] != 2'd0);

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        pop       = 1'b0;
        ex_acc    = ex_req && ex_rdy;
        if (mem_req) begin
            sel_valid = 1'b1;
            sel_addr  = mem_addr;
            sel_data  = mem_data;
        end else if (fifo_count != 2'd0) begin
            sel_valid = 1'b1;
            sel_addr  = head_addr;
            sel_data  = head_data;
            pop       = 1'b1;
        end else if (ex_acc) begin
            sel_valid = 1'b1;
            sel_addr  = ex_addr;
            sel_data  = ex_data;
        end
        push = ex_acc && (mem_req || (fifo_count != 2'd0));
    end

    // Squashed entries always share mem_addr, so their retirement folds
    // into that register's decrement; result saturates at zero.
    always_comb begin
        logic [2:0] up;
        logic [2:0] dn;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            up = {1'b0, cnt_q[r]}
               + {2'b0, (iss_fire && (iss_addr == REG_ADDR_W'(r)))};
            dn = {2'b0, (sel_valid && (sel_addr == REG_ADDR_W'(r)))}
               + ((mem_req && (mem_addr == REG_ADDR_W'(r))) ? {1'b0, squash_cnt} : 3'd0);
            cnt_d[r] = (up > dn) ? 2'(up - dn) : 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= '0;
            end
            gpr_we_     <= DISABLE_;
            gpr_wr_addr <= '0;
            gpr_wr_data <= '0;
        end else begin
            cnt_q   <= cnt_d;
            gpr_we_ <= sel_valid ? ENABLE_ : DISABLE_;
            if (sel_valid) begin
                gpr_wr_addr <= sel_addr;
                gpr_wr_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: arbitration, FIFO squash, scoreboard
// stalls and mid-operation reset, with hand-computed expectations.
module tb_gpr_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_rdy;
    logic        ex_req;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        ex_rdy;
    logic        mem_req;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  rd_addr_0, rd_addr_1;
    logic        rd_stall_0, rd_stall_1;
    logic        gpr_we_;
    logic [4:0]  gpr_wr_addr;
    logic [31:0] gpr_wr_data;

    int checks = 0;
    int errors = 0;

    gpr_wb_ctrl #(
        .REG_NUM     (32),
        .REG_ADDR_W  (5),
        .WORD_DATA_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .iss_rdy     (iss_rdy),
        .ex_req      (ex_req),
        .ex_addr     (ex_addr),
        .ex_data     (ex_data),
        .ex_rdy      (ex_rdy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .rd_addr_0   (rd_addr_0),
        .rd_addr_1   (rd_addr_1),
        .rd_stall_0  (rd_stall_0),
        .rd_stall_1  (rd_stall_1),
        .gpr_we_     (gpr_we_),
        .gpr_wr_addr (gpr_wr_addr),
        .gpr_wr_data (gpr_wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(gpr_we_), 32'd0);
        chk({tag, "_addr"}, 32'(gpr_wr_addr), 32'(a));
        chk({tag, "_data"}, gpr_wr_data, d);
    endtask

    task automatic iss(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_addr  = a;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        iss_valid = 1'b0; iss_addr = '0;
        ex_req = 1'b0; ex_addr = '0; ex_data = '0;
        mem_req = 1'b0; mem_addr = '0; mem_data = '0;
        rd_addr_0 = '0; rd_addr_1 = '0;
        #2;
        chk("rst_we", 32'(gpr_we_), 32'd1);
        chk("rst_addr", 32'(gpr_wr_addr), 32'd0);
        chk("rst_data", gpr_wr_data, 32'd0);
        chk("rst_ex_rdy", 32'(ex_rdy), 32'd1);
        chk("rst_iss_rdy", 32'(iss_rdy), 32'd1);
        chk("rst_stall0", 32'(rd_stall_0), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Issue r5, then a lone ALU write bypasses straight to the port
        rd_addr_0 = 5'd5;
        iss(5'd5);
        #1 chk("a_stall_pend", 32'(rd_stall_0), 32'd1);
        ex_req = 1'b1; ex_addr = 5'd5; ex_data = 32'h11;
        #1 chk("a_ex_rdy", 32'(ex_rdy), 32'd1);
        tick();
        ex_req = 1'b0;
        wr("a_wr", 5'd5, 32'h11);
        chk("a_stall_clr", 32'(rd_stall_0), 32'd0);
        tick();
        chk("a_idle_we", 32'(gpr_we_), 32'd1);
        chk("a_hold_data", gpr_wr_data, 32'h11);

        // Load and ALU together: load first, ALU one cycle later from FIFO
        iss(5'd3);
        iss(5'd4);
        rd_addr_1 = 5'd4;
        mem_req = 1'b1; mem_addr = 5'd3; mem_data = 32'hA;
        ex_req = 1'b1; ex_addr = 5'd4; ex_data = 32'hB;
        #1 chk("b_ex_rdy0", 32'(ex_rdy), 32'd1);
        tick();
        mem_req = 1'b0; ex_req = 1'b0;
        wr("b_wr_r3", 5'd3, 32'hA);
        chk("b_ex_rdy1", 32'(ex_rdy), 32'd1);
        chk("b_stall_r4", 32'(rd_stall_1), 32'd1);
        tick();
        wr("b_wr_r4", 5'd4, 32'hB);
        chk("b_stall_r4_clr", 32'(rd_stall_1), 32'd0);
        tick();
        chk("b_idle", 32'(gpr_we_), 32'd1);

        // Three back-to-back loads fill the FIFO with ALU writes
        iss(5'd10); iss(5'd10); iss(5'd10);
        iss(5'd11); iss(5'd12);
        iss_addr = 5'd10;
        #1 chk("c_iss_rdy_sat", 32'(iss_rdy), 32'd0);
        mem_req = 1'b1; mem_addr = 5'd10; mem_data = 32'hA0;
        ex_req = 1'b1; ex_addr = 5'd11; ex_data = 32'hB1;
        #1 chk("c_ex_rdy_c1", 32'(ex_rdy), 32'd1);
        tick();
        wr("c_wr1", 5'd10, 32'hA0);
        mem_data = 32'hA1; ex_addr = 5'd12; ex_data = 32'hB2;
        #1 chk("c_ex_rdy_c2", 32'(ex_rdy), 32'd1);
        tick();
        wr("c_wr2", 5'd10, 32'hA1);
        mem_data = 32'hA2; ex_addr = 5'd13; ex_data = 32'hB3;
        #1 chk("c_ex_rdy_full", 32'(ex_rdy), 32'd0);
        tick();
        wr("c_wr3", 5'd10, 32'hA2);
        mem_req = 1'b0; ex_req = 1'b0;
        #1 chk("c_ex_rdy_popcyc", 32'(ex_rdy), 32'd0);
        tick();
        wr("c_drain1", 5'd11, 32'hB1);
        chk("c_ex_rdy_after", 32'(ex_rdy), 32'd1);
        tick();
        wr("c_drain2", 5'd12, 32'hB2);
        tick();
        chk("c_idle", 32'(gpr_we_), 32'd1);
        iss_addr = 5'd10;
        #1 chk("c_iss_rdy_back", 32'(iss_rdy), 32'd1);

        // Load to r7 squashes the queued older ALU write to r7
        iss(5'd20); iss(5'd20);
        iss(5'd7); iss(5'd7); iss(5'd8);
        rd_addr_0 = 5'd7; rd_addr_1 = 5'd8;
        mem_req = 1'b1; mem_addr = 5'd20; mem_data = 32'h20;
        ex_req = 1'b1; ex_addr = 5'd7; ex_data = 32'h1;
        tick();
        wr("d_wr_r20a", 5'd20, 32'h20);
        mem_data = 32'h21; ex_addr = 5'd8; ex_data = 32'h2;
        tick();
        wr("d_wr_r20b", 5'd20, 32'h21);
        chk("d_ex_rdy_full", 32'(ex_rdy), 32'd0);
        ex_req = 1'b0;
        mem_addr = 5'd7; mem_data = 32'h3;
        tick();
        mem_req = 1'b0;
        wr("d_wr_r7", 5'd7, 32'h3);
        chk("d_stall_r7_clr", 32'(rd_stall_0), 32'd0);
        chk("d_stall_r8", 32'(rd_stall_1), 32'd1);
        chk("d_ex_rdy_one", 32'(ex_rdy), 32'd1);
        tick();
        wr("d_wr_r8", 5'd8, 32'h2);
        chk("d_stall_r8_clr", 32'(rd_stall_1), 32'd0);
        tick();
        chk("d_idle", 32'(gpr_we_), 32'd1);

        // Saturate r9, queue two r9 writes, reset during the drain
        iss(5'd9); iss(5'd9); iss(5'd9);
        iss_addr = 5'd9;
        #1 chk("e_iss_rdy_sat", 32'(iss_rdy), 32'd0);
        iss(5'd22); iss(5'd22);
        iss_addr = 5'd9;
        rd_addr_0 = 5'd9; rd_addr_1 = 5'd22;
        mem_req = 1'b1; mem_addr = 5'd22; mem_data = 32'h220;
        ex_req = 1'b1; ex_addr = 5'd9; ex_data = 32'h91;
        tick();
        ex_data = 32'h92; mem_data = 32'h221;
        tick();
        mem_req = 1'b0; ex_req = 1'b0;
        tick();
        wr("e_drain1", 5'd9, 32'h91);
        chk("e_stall_r9", 32'(rd_stall_0), 32'd1);
        reset = 1'b1;
        #1;
        chk("e_rst_we", 32'(gpr_we_), 32'd1);
        chk("e_rst_stall0", 32'(rd_stall_0), 32'd0);
        chk("e_rst_stall1", 32'(rd_stall_1), 32'd0);
        chk("e_rst_ex_rdy", 32'(ex_rdy), 32'd1);
        chk("e_rst_iss_rdy", 32'(iss_rdy), 32'd1);
        chk("e_rst_addr", 32'(gpr_wr_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("e_post_we1", 32'(gpr_we_), 32'd1);
        tick();
        chk("e_post_we2", 32'(gpr_we_), 32'd1);
        chk("e_post_ex_rdy", 32'(ex_rdy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
